loading_unit: RTL and testbench

- Host-to-target counterpart of the state dumping path: consumes the byte stream from the UART receiver and parses framed program-load commands.
- Assembles little-endian 32-bit words and writes them into instruction memory.
- Holds the core in reset-hold while a frame is in progress, and reports completion, byte errors and timeouts to the debug controller.

---
 rtl/loading_unit.sv | 173 +++++++++++++++++
 tb/tb_loading_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/loading_unit.sv
// loading_unit: parses framed program-load commands arriving on the UART RX
// byte stream, assembles little-endian 32-bit words and writes them into
// instruction memory. The core is held (busy_o) while a frame is in progress.
// Frame: SYNC, LEN_LO, LEN_HI, LEN*4 payload bytes, CHK (XOR of all but SYNC).
module loading_unit #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hC0,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        busy_o,
  output logic        load_done_o,
  output logic        load_error_o,
  output logic [1:0]  error_code_o,
  output logic [15:0] words_written_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_CHECKSUM = 2'd1,
    ERR_LENGTH   = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_t;

  state_t      state, state_nxt;
  err_t        err_nxt;

  logic [15:0] length;
  logic [7:0]  checksum;
  logic [1:0]  byte_idx;
  logic [23:0] word_lo;     // bytes 0..2 of the word being assembled
  logic [31:0] tmo_cnt;     // cycles since the last byte inside a frame

  logic        sync_seen;
  logic        active;
  logic        timeout_hit;
  logic [15:0] len_full;
  logic        len_too_big;
  logic        last_word;

  assign sync_seen   = rx_valid_i && (rx_data_i == SYNC_BYTE);
  // The idle-gap watchdog only runs while waiting for frame bytes.
  assign active      = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_DATA)   || (state == S_CHECK);
  // A byte arriving in the timeout cycle wins: it is consumed instead.
  assign timeout_hit = active && !rx_valid_i &&
                       (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign len_full    = {rx_data_i, length[7:0]};
  assign len_too_big = 32'(len_full) > MAX_WORDS;
  assign last_word   = (words_written_o + 16'd1) == length;

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is always updated with non-blocking assignments
    // so every flop samples pre-edge values regardless of block ordering.
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic, including the error cause for entries into S_ERROR.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    err_nxt   = ERR_NONE;
    case (state)
      S_IDLE:   if (sync_seen) state_nxt = S_LEN_LO;
      S_LEN_LO: if (rx_valid_i) state_nxt = S_LEN_HI;
      S_LEN_HI: if (rx_valid_i) begin
        if (len_too_big) begin
          state_nxt = S_ERROR;
          err_nxt   = ERR_LENGTH;
        end else if (len_full == 16'd0) begin
          state_nxt = S_CHECK;
        end else begin
          state_nxt = S_DATA;
        end
      end
      S_DATA:   if (rx_valid_i && (byte_idx == 2'd3) && last_word) state_nxt = S_CHECK;
      S_CHECK:  if (rx_valid_i) begin
        if (rx_data_i == checksum) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_ERROR;
          err_nxt   = ERR_CHECKSUM;
        end
      end
      // Both terminal states last one cycle; bytes arriving meanwhile are dropped.
      S_DONE, S_ERROR: state_nxt = S_IDLE;
      default:         state_nxt = S_IDLE;
    endcase
    if (timeout_hit) begin
      state_nxt = S_ERROR;
      err_nxt   = ERR_TIMEOUT;
    end
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy_o       = (state != S_IDLE);
    load_done_o  = (state == S_DONE);
    load_error_o = (state == S_ERROR);
  end

  // Datapath: length/checksum capture, word assembly, memory writes, watchdog.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      imem_we_o       <= 1'b0;
      imem_addr_o     <= '0;
      imem_wdata_o    <= '0;
      error_code_o    <= '0;
      words_written_o <= '0;
      length          <= '0;
      checksum        <= '0;
      byte_idx        <= '0;
      word_lo         <= '0;
      tmo_cnt         <= '0;
    end else begin
      imem_we_o <= 1'b0;

      if (!active || rx_valid_i) tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + 32'd1;

      case (state)
        S_IDLE: if (sync_seen) begin
          error_code_o    <= ERR_NONE;
          words_written_o <= '0;
          checksum        <= '0;
          byte_idx        <= '0;
        end
        S_LEN_LO: if (rx_valid_i) begin
          length[7:0] <= rx_data_i;
          checksum    <= checksum ^ rx_data_i;
        end
        S_LEN_HI: if (rx_valid_i) begin
          length[15:8] <= rx_data_i;
          checksum     <= checksum ^ rx_data_i;
          byte_idx     <= '0;
        end
        S_DATA: if (rx_valid_i) begin
          checksum <= checksum ^ rx_data_i;
          byte_idx <= byte_idx + 2'd1;
          case (byte_idx)
            2'd0: word_lo[7:0]   <= rx_data_i;
            2'd1: word_lo[15:8]  <= rx_data_i;
            2'd2: word_lo[23:16] <= rx_data_i;
            default: begin
              imem_we_o       <= 1'b1;
              imem_wdata_o    <= {rx_data_i, word_lo};
              imem_addr_o     <= BASE_ADDR + {14'd0, words_written_o, 2'b00};
              words_written_o <= words_written_o + 16'd1;
            end
          endcase
        end
        default: ;
      endcase

      if (state_nxt == S_ERROR) error_code_o <= err_nxt;
    end
  end

endmodule

// File: tb/tb_loading_unit.sv
// tb_loading_unit: randomized frame stimulus with a scoreboard. The frame
// sender predicts writes and the completion event from the frame contents;
// a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_loading_unit;

  localparam int unsigned TMO  = 50;
  localparam int unsigned MAXW = 1024;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        load_done;
  logic        load_error;
  logic [1:0]  error_code;
  logic [15:0] words_written;

  always #5 clk = ~clk;

  loading_unit #(
    .SYNC_BYTE(8'hC0), .MAX_WORDS(MAXW), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
    .busy_o(busy), .load_done_o(load_done), .load_error_o(load_error),
    .error_code_o(error_code), .words_written_o(words_written)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] count;
  } wr_t;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [15:0] words;
  } ev_t;

  wr_t wr_q[$];
  ev_t ev_q[$];
  wr_t mon_w;
  ev_t mon_e;

  int vectors     = 0;
  int miscompares = 0;
  int events_seen = 0;
  int cyc         = 0;
  int last_strobe = 0;

  logic [31:0] payload [MAXW];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Cycle stamp of the edge that sampled the most recent byte strobe.
  always @(posedge clk) begin
    if (rx_valid) last_strobe <= cyc;
    cyc <= cyc + 1;
  end

  // Monitor: compare every write pulse and every done/error pulse.
  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, no write expected",
                 imem_addr, imem_wdata);
      end else begin
        mon_w = wr_q.pop_front();
        check("wr_addr", imem_addr, mon_w.addr);
        check("wr_data", imem_wdata, mon_w.data);
        check("wr_count", 32'(words_written), 32'(mon_w.count));
      end
    end
    if (load_done || load_error) begin
      events_seen++;
      if (ev_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: done=%0b error=%0b code=%0d, no event expected",
                 load_done, load_error, error_code);
      end else begin
        mon_e = ev_q.pop_front();
        check("ev_kind", 32'({load_error, load_done}), mon_e.is_err ? 32'd2 : 32'd1);
        check("ev_code", 32'(error_code), 32'(mon_e.code));
        check("ev_words", 32'(words_written), 32'(mon_e.words));
        if (mon_e.code == 2'd3) check("tmo_latency", 32'(cyc - last_strobe - 1), TMO);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat ($urandom_range(gap_max, 0)) @(negedge clk);
  endtask

  task automatic wait_event(input int start);
    int n = 0;
    while (events_seen == start && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (events_seen == start) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_end: no done/error pulse within 400 cycles");
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    32'(imem_we), 32'd0);
    check({tag, "_addr"},  imem_addr, 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(load_done), 32'd0);
    check({tag, "_error"}, 32'(load_error), 32'd0);
    check({tag, "_code"},  32'(error_code), 32'd0);
    check({tag, "_words"}, 32'(words_written), 32'd0);
  endtask

  // Reference model + driver: predict the outcome of a frame whose first
  // pay_bytes payload bytes (and optionally the checksum) are sent.
  task automatic send_frame(input logic [15:0] len, input int pay_bytes,
                            input bit send_chk, input bit corrupt, input int gap_max);
    logic [7:0] chk;
    ev_t        e;
    wr_t        w;
    int         start;
    start = events_seen;
    chk   = len[7:0] ^ len[15:8];
    if (32'(len) > MAXW) begin
      e.is_err = 1'b1; e.code = 2'd2; e.words = 16'd0;
      ev_q.push_back(e);
      send_byte(8'hC0, gap_max);
      send_byte(len[7:0], gap_max);
      send_byte(len[15:8], gap_max);
    end else begin
      for (int i = 0; i < int'(len); i++)
        for (int k = 0; k < 4; k++) chk = chk ^ payload[i][8*k +: 8];
      for (int i = 0; i < pay_bytes / 4; i++) begin
        w.addr  = BASE + 32'(4 * i);
        w.data  = payload[i];
        w.count = 16'(i + 1);
        wr_q.push_back(w);
      end
      if (send_chk && pay_bytes == 4 * int'(len)) begin
        e.is_err = corrupt;
        e.code   = corrupt ? 2'd1 : 2'd0;
        e.words  = len;
      end else begin
        e.is_err = 1'b1; e.code = 2'd3; e.words = 16'(pay_bytes / 4);
      end
      ev_q.push_back(e);
      send_byte(8'hC0, gap_max);
      send_byte(len[7:0], gap_max);
      send_byte(len[15:8], gap_max);
      for (int b = 0; b < pay_bytes; b++) send_byte(payload[b / 4][8 * (b % 4) +: 8], gap_max);
      if (send_chk) send_byte(corrupt ? ~chk : chk, gap_max);
    end
    wait_event(start);
    repeat (2) @(negedge clk);
    check("busy_after", 32'(busy), 32'd0);
    check("code_held", 32'(error_code), 32'(e.code));
  endtask

  task automatic randomize_payload(input int n);
    for (int i = 0; i < n; i++) begin
      payload[i] = $urandom();
      if ($urandom_range(7, 0) == 0) payload[i][7:0] = 8'hC0;  // sync value as data
    end
  endtask

  initial begin
    rst_i    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_i = 1'b0;

    // Two-word directed frame, clean and with a corrupted checksum.
    payload[0] = 32'hDEAD_BEEF;
    payload[1] = 32'h1234_5678;
    send_frame(16'd2, 8, 1'b1, 1'b0, 3);
    send_frame(16'd2, 8, 1'b1, 1'b1, 3);

    // Leading junk is ignored; zero-length frame completes with no writes.
    send_byte(8'h55, 3);
    send_byte(8'hAA, 3);
    send_frame(16'd0, 0, 1'b1, 1'b0, 3);

    // Over-long length rejected, next frame loads normally.
    send_frame(16'd1025, 0, 1'b0, 1'b0, 3);
    randomize_payload(3);
    send_frame(16'd3, 12, 1'b1, 1'b0, 3);

    // Stall mid-word: timeout after TMO idle cycles, no write.
    payload[0] = 32'h0000_2211;
    send_frame(16'd1, 2, 1'b0, 1'b0, 3);

    // Reset mid-frame abandons it; no write and no later timeout.
    send_byte(8'hC0, 1);
    send_byte(8'h01, 1);
    send_byte(8'h00, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst_i = 1'b0;
    repeat (TMO + 20) @(negedge clk);
    check("midrst_idle_busy", 32'(busy), 32'd0);
    payload[0] = 32'hCAFE_F00D;
    send_frame(16'd1, 4, 1'b1, 1'b0, 3);

    // Randomized frames.
    for (int f = 0; f < 10; f++) begin
      int len;
      len = int'($urandom_range(8, 1));
      randomize_payload(len);
      send_frame(16'(len), 4 * len, 1'b1, 1'($urandom_range(1, 0)), 6);
    end

    // Largest legal frame, back-to-back bytes.
    randomize_payload(int'(MAXW));
    send_frame(16'(MAXW), 4 * int'(MAXW), 1'b1, 1'b0, 0);

    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("ev_q_drained", 32'(ev_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
